// File: rtl/intersection_model.sv
// Two-street traffic queue model: per-street car counters drained while the street's lamp is green.
// Optional lamp-violation checker is built only when IM_VIOLATION_CHECK_EN is defined.

module im_street #(
    parameter int DEPART_CYC = 2,
    parameter int QMAX       = 15
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_green,
    input  logic       i_arr,
    output logic [3:0] o_q,
    output logic       o_t,
    output logic       o_drop
);
    localparam logic [3:0] T_LAST = 4'(DEPART_CYC - 1);
    localparam logic [3:0] Q_MAX  = 4'(QMAX);

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FLOW} st_t;

    st_t        st;
    logic [3:0] tmr, tmr_nxt, q_nxt;
    logic       dep;

    always_comb begin
        dep     = i_green && (o_q != 4'd0) && (tmr == T_LAST);
        q_nxt   = o_q;
        tmr_nxt = 4'd0;
        o_drop  = 1'b0;
        // Timer only runs while cars are present under a green lamp; yellow clears it.
        if (i_green && o_q != 4'd0)
            tmr_nxt = dep ? 4'd0 : tmr + 4'd1;
        case ({i_arr, dep})
            2'b10: begin
                if (o_q == Q_MAX) o_drop = 1'b1;
                else              q_nxt  = o_q + 4'd1;
            end
            2'b01:   q_nxt = o_q - 4'd1;
            default: q_nxt = o_q;
        endcase
        if (q_nxt == 4'd0) tmr_nxt = 4'd0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            st  <= ST_EMPTY;
            o_q <= 4'd0;
            tmr <= 4'd0;
        end else begin
            o_q <= q_nxt;
            tmr <= tmr_nxt;
            if (q_nxt == 4'd0) st <= ST_EMPTY;
            else if (i_green)  st <= ST_FLOW;
            else               st <= ST_WAIT;
        end
    end

    // State is EMPTY exactly when the registered count is zero.
    assign o_t = (st != ST_EMPTY);
endmodule

module intersection_model #(
    parameter int DEPART_CYC = 2,
    parameter int QMAX       = 15
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [47:0] i_la,
    input  logic [47:0] i_lb,
    input  logic        i_arr_a,
    input  logic        i_arr_b,
    output logic        o_ta,
    output logic        o_tb,
    output logic [3:0]  o_qa,
    output logic [3:0]  o_qb,
    output logic        o_ovf,
    output logic        o_err
);
    localparam int NUM_ST = 2;
    localparam logic [47:0] L_RED    = "red";
    localparam logic [47:0] L_YELLOW = "yellow";
    localparam logic [47:0] L_GREEN  = "green";

    typedef enum logic [1:0] {LP_RED, LP_YELLOW, LP_GREEN, LP_INVALID} lamp_t;

    function automatic lamp_t decode(input logic [47:0] v);
        if (v == L_RED)         return LP_RED;
        else if (v == L_YELLOW) return LP_YELLOW;
        else if (v == L_GREEN)  return LP_GREEN;
        else                    return LP_INVALID;
    endfunction

    lamp_t [NUM_ST-1:0]      lamp;
    logic  [NUM_ST-1:0]      green, arr, t, drop;
    logic  [NUM_ST-1:0][3:0] q;

    assign lamp[0] = decode(i_la);
    assign lamp[1] = decode(i_lb);
    assign arr     = {i_arr_b, i_arr_a};

    generate
        for (genvar s = 0; s < NUM_ST; s++) begin : g_st
            assign green[s] = (lamp[s] == LP_GREEN);
            im_street #(.DEPART_CYC(DEPART_CYC), .QMAX(QMAX)) u_st (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_green (green[s]),
                .i_arr   (arr[s]),
                .o_q     (q[s]),
                .o_t     (t[s]),
                .o_drop  (drop[s])
            );
        end
    endgenerate

    assign o_qa = q[0];
    assign o_qb = q[1];
    assign o_ta = t[0];
    assign o_tb = t[1];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) o_ovf <= 1'b0;
        else if (|drop) o_ovf <= 1'b1;
    end

`ifdef IM_VIOLATION_CHECK_EN
    logic viol;
    // Two non-red lamps conflict; an undecodable lamp is a fault on its own.
    assign viol = ((lamp[0] != LP_RED) && (lamp[1] != LP_RED)) ||
                  (lamp[0] == LP_INVALID) || (lamp[1] == LP_INVALID);

    always_ff @(posedge i_clk) begin
        if (!i_rstn)   o_err <= 1'b0;
        else if (viol) o_err <= 1'b1;
    end
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: doc/intersection_model.md
INTERSECTION_MODEL -- requirements
Module: intersection_model

Interface
REQ-001 Parameter DEPART_CYC, default 2: cycles of green a queued car needs to leave (legal range 1..15).
REQ-002 Parameter QMAX, default 15: queue capacity per street (legal range 1..15; counters are 4 bits).
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rstn  input  1  reset: synchronous, active-low.
REQ-005 i_la  input  48  street-A lamp, 6-char ASCII, right-aligned, zero-padded: "green", "yellow" or "red".
REQ-006 i_lb  input  48  street-B lamp, same encoding as i_la.
REQ-007 i_arr_a  input  1  one car arrives on street A this cycle.
REQ-008 i_arr_b  input  1  one car arrives on street B this cycle.
REQ-009 o_ta  output  1  street-A traffic sensor: high while o_qa != 0.
REQ-010 o_tb  output  1  street-B traffic sensor: high while o_qb != 0.
REQ-011 o_qa  output  4  street-A queue count, registered.
REQ-012 o_qb  output  4  street-B queue count, registered.
REQ-013 o_ovf  output  1  sticky flag: an arrival was dropped because the queue was full.
REQ-014 o_err  output  1  sticky flag: lamp violation (see Configuration).

Function
REQ-015 Each lamp input SHALL be decoded combinationally, by exact 48-bit compare, to one of RED, YELLOW, GREEN or INVALID; any other pattern is INVALID.
REQ-016 Each street SHALL run an independent 3-state FSM:
- EMPTY: q==0.
- WAIT: q>0 and lamp not GREEN.
- FLOW: q>0 and lamp GREEN.
REQ-017 In FLOW, a per-street departure timer SHALL count 0..DEPART_CYC-1; on the cycle it reaches DEPART_CYC-1, q SHALL decrement by 1 and the timer SHALL return to 0.
REQ-018 The timer SHALL clear to 0 on any cycle the lamp is not GREEN, including YELLOW; cars do not depart on yellow.
REQ-019 The timer SHALL clear to 0 when q becomes 0.
REQ-020 An arrival with q<QMAX SHALL increment q at the same edge.
REQ-021 If an arrival and a departure fall on the same cycle, q SHALL stay unchanged.
REQ-022 An arrival with q==QMAX and no departure that cycle SHALL be dropped, q SHALL stay QMAX, and o_ovf SHALL set.
REQ-023 If an arrival with q==QMAX coincides with a departure, q SHALL stay QMAX and no drop SHALL be flagged.
REQ-024 o_ta/o_tb SHALL be derived combinationally from the registered counts: an arrival sampled at edge n raises o_ta immediately after edge n.
REQ-025 Queue counts SHALL never wrap below 0 or above QMAX.
REQ-026 o_ovf and o_err SHALL remain set until reset.

Reset
REQ-027 When i_rstn==0 at a rising edge, o_qa, o_qb, both timers, o_ovf and o_err SHALL become 0, and both FSMs SHALL enter EMPTY.
REQ-028 Arrivals SHALL be ignored on any edge where i_rstn==0.
REQ-029 Reset mid-departure SHALL discard the partial timer count.

Configuration
REQ-030 With IM_VIOLATION_CHECK_EN defined, o_err SHALL set on the edge after any cycle in which:
- both lamps decode to non-RED, or
- either lamp decodes to INVALID.
REQ-031 With IM_VIOLATION_CHECK_EN undefined, o_err SHALL be tied to 0 and no checker logic SHALL be built; queue behaviour is identical in both builds.

Verification
REQ-032 Reset, then i_arr_a pulsed 3 cycles with i_la="red" -> o_qa=3, o_ta=1, o_qa holds 3 for 10 further cycles.
REQ-033 o_qa=3, DEPART_CYC=2, i_la="green" -> o_qa steps 2,1,0 at 2-cycle intervals; o_ta falls with o_qa=0.
REQ-034 o_qa=2, i_la="green" for 1 cycle, then "yellow" for 5 cycles -> o_qa stays 2 (timer cleared on yellow).
REQ-035 o_qb=15, i_arr_b=1, i_lb="red" -> o_qb=15, o_ovf=1.
REQ-036 o_qb=15, i_arr_b=1 coincident with a departure edge -> o_qb=15, o_ovf=0.
REQ-037 IM_VIOLATION_CHECK_EN defined, i_la="green", i_lb="yellow" for 1 cycle -> o_err=1, still 1 after lamps return legal; i_rstn low 1 edge -> all outputs 0.
